// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters and the register-file write arbiter.
// master = upstream writeback sources, slave = the arbiter.
interface regfile_write_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
) ();
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_num;
  logic [DW-1:0] req0_data;

  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_num;
  logic [DW-1:0] req1_data;

  logic          reg_we;
  logic [AW-1:0] dstreg_num;
  logic [DW-1:0] dstreg_data;
  logic          busy;

  modport master (
    output req0_valid, req0_num, req0_data,
    output req1_valid, req1_num, req1_data,
    input  req0_ready, req1_ready,
    input  reg_we, dstreg_num, dstreg_data, busy
  );

  modport slave (
    input  req0_valid, req0_num, req0_data,
    input  req1_valid, req1_num, req1_data,
    output req0_ready, req1_ready,
    output reg_we, dstreg_num, dstreg_data, busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two in-order writeback FIFOs drained round-robin into one registered register_file write port.
// Optional combinational forwarding lookup over pending writes when RF_WR_FWD_EN is defined.
module regfile_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus
`ifdef RF_WR_FWD_EN
  ,
  input  logic [AW-1:0]          fwd_num1,
  input  logic [AW-1:0]          fwd_num2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [DW-1:0]          fwd_data1,
  output logic [DW-1:0]          fwd_data2
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = AW + DW;

  typedef enum logic {FAV_REQ0, FAV_REQ1} rr_t;

  logic [1:0]    in_valid;
  logic [1:0]    not_empty;
  logic [1:0]    full;
  logic [1:0]    pop;
  logic [AW-1:0] in_num  [2];
  logic [DW-1:0] in_data [2];
  logic [EW-1:0] head    [2];

  rr_t           rr_reg, rr_next;
  logic          reg_we_reg;
  logic [AW-1:0] dstreg_num_reg;
  logic [DW-1:0] dstreg_data_reg;

`ifdef RF_WR_FWD_EN
  logic [PW:0]   rd_view  [2];
  logic [PW:0]   occ_view [2];
  logic [EW-1:0] mem_view [2][DEPTH];
`endif

  assign in_valid   = {bus.req1_valid, bus.req0_valid};
  assign in_num[0]  = bus.req0_num;
  assign in_num[1]  = bus.req1_num;
  assign in_data[0] = bus.req0_data;
  assign in_data[1] = bus.req1_data;

  // Ready comes from registered pointers only, so a pop never opens a full FIFO early.
  assign bus.req0_ready = !full[0];
  assign bus.req1_ready = !full[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [PW:0]   wr_ptr_reg;
      logic [PW:0]   rd_ptr_reg;
      logic [EW-1:0] mem_reg [DEPTH];
      logic          push;

      assign full[gi]      = (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]) &&
                             (wr_ptr_reg[PW] != rd_ptr_reg[PW]);
      assign not_empty[gi] = (wr_ptr_reg != rd_ptr_reg);
      // Writes to r0 complete the handshake but are dropped here.
      assign push          = in_valid[gi] && !full[gi] && (in_num[gi] != '0);
      assign head[gi]      = mem_reg[rd_ptr_reg[PW-1:0]];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (push)
          mem_reg[wr_ptr_reg[PW-1:0]] <= {in_num[gi], in_data[gi]};
      end

`ifdef RF_WR_FWD_EN
      assign rd_view[gi]  = rd_ptr_reg;
      assign occ_view[gi] = wr_ptr_reg - rd_ptr_reg;
      for (genvar gk = 0; gk < DEPTH; gk++) begin : g_view
        assign mem_view[gi][gk] = mem_reg[gk];
      end
`endif
    end
  endgenerate

  // The favour pointer only moves when both FIFOs compete for the write port.
  always_comb begin
    pop     = 2'b00;
    rr_next = rr_reg;
    if (not_empty == 2'b11) begin
      if (rr_reg == FAV_REQ0) begin
        pop     = 2'b01;
        rr_next = FAV_REQ1;
      end else begin
        pop     = 2'b10;
        rr_next = FAV_REQ0;
      end
    end else begin
      pop = not_empty;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_reg          <= FAV_REQ0;
      reg_we_reg      <= 1'b0;
      dstreg_num_reg  <= '0;
      dstreg_data_reg <= '0;
    end else begin
      rr_reg     <= rr_next;
      reg_we_reg <= |pop;
      if (pop[1])
        {dstreg_num_reg, dstreg_data_reg} <= head[1];
      else if (pop[0])
        {dstreg_num_reg, dstreg_data_reg} <= head[0];
    end
  end

  assign bus.reg_we      = reg_we_reg;
  assign bus.dstreg_num  = dstreg_num_reg;
  assign bus.dstreg_data = dstreg_data_reg;
  assign bus.busy        = (|not_empty) || reg_we_reg;

`ifdef RF_WR_FWD_EN
  logic [AW-1:0] fwd_q [2];
  logic          fwd_h [2];
  logic [DW-1:0] fwd_d [2];

  assign fwd_q[0]  = fwd_num1;
  assign fwd_q[1]  = fwd_num2;
  assign fwd_hit1  = fwd_h[0];
  assign fwd_hit2  = fwd_h[1];
  assign fwd_data1 = fwd_d[0];
  assign fwd_data2 = fwd_d[1];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic          hit;
      logic [DW-1:0] data;

      // Scan oldest to youngest, write stage first and req1 last, so later matches win.
      always_comb begin
        logic [PW-1:0] slot;
        hit  = 1'b0;
        data = '0;
        slot = '0;
        if (fwd_q[gi] != '0) begin
          if (reg_we_reg && (dstreg_num_reg == fwd_q[gi])) begin
            hit  = 1'b1;
            data = dstreg_data_reg;
          end
          for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
              slot = rd_view[r][PW-1:0] + PW'(k);
              if (((PW+1)'(k) < occ_view[r]) &&
                  (mem_view[r][slot][EW-1:DW] == fwd_q[gi])) begin
                hit  = 1'b1;
                data = mem_view[r][slot][DW-1:0];
              end
            end
          end
        end
      end

      assign fwd_h[gi] = hit;
      assign fwd_d[gi] = data;
    end
  endgenerate
`endif
endmodule
